// File: rtl/trace_pkg.sv
// Shared types and constants for the trace record scheduler.
package trace_pkg;

    // Capture sequencer states; encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int unsigned LANS_DEF = 4;
    localparam int unsigned NREQ_DEF = 2 * LANS_DEF;

    // Requester index for the default lane count.
    typedef logic [$clog2(NREQ_DEF)-1:0] req_idx_t;

    // RX lanes occupy requesters 0..LANS-1, TX lanes LANS..2*LANS-1.
    localparam int unsigned RX_BASE = 0;

    function automatic int unsigned tx_base(input int unsigned lans);
        return lans;
    endfunction

endpackage

// File: rtl/trace_sched_if.sv
// Requester and record-output bundle for trace_sched.
interface trace_sched_if #(
    parameter int unsigned LANS = 4,
    parameter int unsigned DW   = 32
);
    localparam int unsigned NREQ = 2 * LANS;
    localparam int unsigned KW   = DW / 8;
    localparam int unsigned SW   = $clog2(NREQ);

    logic [NREQ*DW-1:0] req_dat;
    logic [NREQ*KW-1:0] req_k;
    logic [NREQ-1:0]    req_v;
    logic [NREQ-1:0]    req_rdy;

    logic [63:0]        out_time;
    logic [SW-1:0]      out_src;
    logic [DW-1:0]      out_dat;
    logic [KW-1:0]      out_k;
    logic               out_valid;
    logic               out_ready;

    // Environment side: lane taps plus the downstream writer's ready.
    modport master (
        output req_dat, req_k, req_v, out_ready,
        input  req_rdy, out_time, out_src, out_dat, out_k, out_valid
    );

    // Scheduler side.
    modport slave (
        input  req_dat, req_k, req_v, out_ready,
        output req_rdy, out_time, out_src, out_dat, out_k, out_valid
    );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first request at or above the pointer, with wrap.
module rr_arb #(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Walk candidates ptr, ptr+1, ... modulo N and keep the first one requesting.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_cand = w_sum[IW-1:0];
            if (!o_vld && i_req[w_cand]) begin
                o_vld         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_sched.sv
// Round-robin trace record scheduler with arm/trigger/stop capture sequencing.
module trace_sched
    import trace_pkg::*;
#(
    parameter int unsigned LANS = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned CW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    trace_sched_if.slave  bus,
    input  logic          arm,
    input  logic          trig,
    input  logic          stop,
    input  logic [CW-1:0] cap_len,
    output logic [1:0]    state,
    output logic [CW-1:0] rec_cnt
);

    localparam int unsigned NREQ = 2 * LANS;
    localparam int unsigned KW   = DW / 8;
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t         r_state;
    logic [CW-1:0]  r_len;
    logic [CW-1:0]  r_cnt;
    logic [IW-1:0]  r_ptr;
    logic [63:0]    r_time;
    logic           r_ovalid;
    logic [63:0]    r_otime;
    logic [IW-1:0]  r_osrc;
    logic [DW-1:0]  r_odat;
    logic [KW-1:0]  r_ok;

    logic           w_cap;
    logic           w_can_load;
    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]  w_idx;
    logic           w_vld;
    logic           w_grant;
    logic [IW-1:0]  w_ptr_nxt;
    logic [CW-1:0]  w_cnt_inc;
    logic           w_len_hit;

    assign w_cap      = (r_state == ST_CAPTURE);
    assign w_can_load = !r_ovalid || bus.out_ready;
    assign w_req      = (w_cap && w_can_load) ? bus.req_v : '0;

    rr_arb #(
        .N (NREQ)
    ) u_arb (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

    assign w_grant   = w_vld;
    assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    assign w_len_hit = w_grant && (r_len != '0) && (w_cnt_inc == r_len);

    // Outside capture every requester is drained; inside only the winner sees ready.
    assign bus.req_rdy   = w_cap ? w_gnt : '1;
    assign bus.out_time  = r_otime;
    assign bus.out_src   = r_osrc;
    assign bus.out_dat   = r_odat;
    assign bus.out_k     = r_ok;
    assign bus.out_valid = r_ovalid;
    assign state         = r_state;
    assign rec_cnt       = r_cnt;

    // Free-running timestamp, RR pointer and the single-entry output record register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_time   <= '0;
            r_ptr    <= '0;
            r_ovalid <= 1'b0;
            r_otime  <= '0;
            r_osrc   <= '0;
            r_odat   <= '0;
            r_ok     <= '0;
        end else begin
            r_time <= r_time + 64'd1;
            if (w_grant) begin
                r_ovalid <= 1'b1;
                r_otime  <= r_time;
                r_osrc   <= w_idx;
                r_odat   <= bus.req_dat[w_idx*DW +: DW];
                r_ok     <= bus.req_k[w_idx*KW +: KW];
                r_ptr    <= w_ptr_nxt;
            end else if (bus.out_ready) begin
                r_ovalid <= 1'b0;
            end
        end
    end

    // Capture sequencer; arm overrides trig/stop and restarts from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
        end else if (arm) begin
            r_state <= ST_ARMED;
            r_len   <= cap_len;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (trig) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_grant) begin
                        r_cnt <= w_cnt_inc;
                    end
                    if (stop || w_len_hit) begin
                        r_state <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_sched.sv
// Directed plus randomized bench for trace_sched against a cycle-level behavioural model.
module tb_trace_sched;
    import trace_pkg::*;

    localparam int unsigned LANS = 4;
    localparam int unsigned NREQ = 2 * LANS;
    localparam int unsigned DW   = 32;
    localparam int unsigned KW   = DW / 8;
    localparam int unsigned CW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          trig;
    logic          stop;
    logic [CW-1:0] cap_len;
    logic [1:0]    state;
    logic [CW-1:0] rec_cnt;

    trace_sched_if #(.LANS(LANS), .DW(DW)) bus();

    trace_sched #(
        .LANS (LANS),
        .DW   (DW),
        .CW   (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .arm     (arm),
        .trig    (trig),
        .stop    (stop),
        .cap_len (cap_len),
        .state   (state),
        .rec_cnt (rec_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: 0=IDLE 1=ARMED 2=CAPTURE 3=DONE
    int            m_state = 0;
    logic [CW-1:0] m_len   = '0;
    logic [CW-1:0] m_cnt   = '0;
    int            m_ptr   = 0;
    logic [63:0]   m_time  = '0;
    bit            m_ov    = 1'b0;
    int            m_src   = 0;
    logic [DW-1:0] m_dat   = '0;
    logic [KW-1:0] m_k     = '0;
    logic [63:0]   m_otime = '0;
    logic [63:0]   last_t  = '0;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_dat[i*DW +: DW] = $urandom;
            bus.req_k[i*KW +: KW]   = KW'($urandom);
        end
    endtask

    // One clock: predict the grant, check ready before the edge, advance model, check outputs after.
    task automatic cycle();
        int              g;
        int              c;
        bit              cap;
        logic [NREQ-1:0] exp_rdy;
        #1;
        cap = (m_state == 2);
        g   = -1;
        if (cap && (!m_ov || bus.out_ready)) begin
            for (int j = 0; j < NREQ; j++) begin
                c = (m_ptr + j) % NREQ;
                if (g < 0 && bus.req_v[c]) g = c;
            end
        end
        exp_rdy = '1;
        if (cap) begin
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        if (!rst) chk("req_rdy", bus.req_rdy, exp_rdy);
        last_t = m_time;
        @(posedge clk);
        #1;
        if (rst) begin
            m_state = 0; m_len = '0; m_cnt = '0; m_ptr = 0; m_time = '0;
            m_ov = 1'b0; m_src = 0; m_dat = '0; m_k = '0; m_otime = '0;
        end else begin
            if (g >= 0) begin
                m_ov    = 1'b1;
                m_src   = g;
                m_dat   = bus.req_dat[g*DW +: DW];
                m_k     = bus.req_k[g*KW +: KW];
                m_otime = m_time;
                m_ptr   = (g + 1) % NREQ;
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
            if (arm) begin
                m_state = 1; m_len = cap_len; m_cnt = '0;
            end else if (m_state == 1 && trig) begin
                m_state = 2;
            end else if (m_state == 2) begin
                if (g >= 0 && m_cnt != '1) m_cnt = m_cnt + 1;
                if (stop || (g >= 0 && m_len != 0 && m_cnt == m_len)) m_state = 3;
            end
            m_time = m_time + 1;
        end
        chk("out_valid", bus.out_valid, m_ov);
        chk("state", state, m_state);
        chk("rec_cnt", rec_cnt, m_cnt);
        chk("out_time", bus.out_time, m_otime);
        chk("out_src", bus.out_src, m_src);
        chk("out_dat", bus.out_dat, m_dat);
        chk("out_k", bus.out_k, m_k);
    endtask

    task automatic arm_trig(input logic [CW-1:0] len);
        bus.req_v = '0;
        arm = 1'b1; cap_len = len;
        cycle();
        arm = 1'b0; trig = 1'b1;
        cycle();
        trig = 1'b0;
    endtask

    initial begin
        int          src_exp [3];
        logic [63:0] t_prev;
        logic [DW-1:0] d_exp;
        src_exp = '{0, 7, 0};

        rst = 1'b1; arm = 1'b0; trig = 1'b0; stop = 1'b0; cap_len = '0;
        bus.req_v = '0; bus.req_dat = '0; bus.req_k = '0; bus.out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_cnt", rec_cnt, 0);
        chk("rst_time", bus.out_time, 0);

        // Idle drain
        bus.req_v = '1;
        rand_data();
        repeat (10) cycle();
        chk("idle_rdy", bus.req_rdy, 8'hFF);
        chk("idle_valid", bus.out_valid, 0);

        // Bounded capture, two requesters at opposite ends
        arm_trig(3);
        chk("cap_state", state, 2);
        bus.req_v = 8'h81; bus.out_ready = 1'b1;
        t_prev = '0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle();
            chk("rr_src", bus.out_src, src_exp[i]);
            if (i > 0) chk("time_step", bus.out_time, t_prev + 64'd1);
            t_prev = bus.out_time;
        end
        chk("done_state", state, 3);
        chk("done_cnt", rec_cnt, 3);
        cycle();
        chk("drain_valid", bus.out_valid, 0);

        // Backpressure
        arm_trig(0);
        bus.req_v = 8'h02; bus.out_ready = 1'b0;
        rand_data();
        d_exp = bus.req_dat[1*DW +: DW];
        cycle();
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_src", bus.out_src, 1);
        repeat (5) begin
            cycle();
            chk("bp_rdy", bus.req_rdy, 8'h00);
            chk("bp_hold", bus.out_dat, d_exp);
            chk("bp_hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_resume_rdy", bus.req_rdy, 8'h02);
        cycle();
        chk("bp_resume_time", bus.out_time, last_t);
        chk("bp_resume_cnt", rec_cnt, 2);

        // Fairness in unlimited mode from a fresh pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        arm_trig(0);
        bus.req_v = '1; bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_data();
            cycle();
            chk("fair_src", bus.out_src, i % 8);
        end

        // Stop with a pending record
        bus.out_ready = 1'b0; stop = 1'b1;
        d_exp = bus.req_dat[7*DW +: DW];
        cycle();
        stop = 1'b0;
        chk("stop_state", state, 3);
        chk("stop_valid", bus.out_valid, 1);
        chk("stop_src", bus.out_src, 7);
        chk("stop_dat", bus.out_dat, d_exp);
        bus.out_ready = 1'b1;
        cycle();
        chk("stop_accept", bus.out_valid, 0);
        repeat (3) cycle();
        chk("stop_nogrant", bus.out_valid, 0);
        chk("stop_cnt", rec_cnt, 16);

        // Reset in the middle of a capture with a record pending
        arm_trig(0);
        bus.req_v = '1; bus.out_ready = 1'b0;
        rand_data();
        cycle();
        chk("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_time", bus.out_time, 0);
        arm_trig(0);
        bus.req_v = '1; bus.out_ready = 1'b1;
        cycle();
        chk("time_restart", bus.out_time, 2);

        // Randomized traffic and control
        for (int i = 0; i < 400; i++) begin
            bus.req_v     = NREQ'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            arm           = ($urandom_range(0, 29) == 0);
            trig          = ($urandom_range(0, 4) == 0);
            stop          = ($urandom_range(0, 39) == 0);
            cap_len       = CW'($urandom_range(0, 6));
            rst           = ($urandom_range(0, 199) == 0);
            rand_data();
            cycle();
        end
        rst = 1'b0; arm = 1'b0; trig = 1'b0; stop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
